// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 pooling datapath: control states,
// pooling mode encodings and output-map size derivation.
package pool_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StFlush  = 2'd2,
    StDone   = 2'd3
  } pool_state_t;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Output width/height of a 2x2 window with stride 2 (floor for odd sizes).
  function automatic int unsigned pool_out_size(input int unsigned ifm_size);
    return (ifm_size - 2) / 2 + 1;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: previous-row line buffer, left/upper-left window registers and
// the combinational 2x2 max/average combine. Optional fused ReLU when POOL_RELU_EN
// is defined.
module pool_lane
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IFM_SIZE   = 14,
  localparam int unsigned COL_W     = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_accept,
  input  logic [COL_W-1:0]      i_col,
  input  logic                  i_mode_avg,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [DATA_WIDTH-1:0] r_line [IFM_SIZE];
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_up_left;

  logic signed [DATA_WIDTH-1:0] w_a, w_b, w_c, w_d;
  logic signed [DATA_WIDTH-1:0] w_max_top, w_max_bot, w_max;
  logic signed [DATA_WIDTH+1:0] w_sum, w_sum_shr;
  logic signed [DATA_WIDTH-1:0] w_avg, w_pool;

  // Line buffer and window registers. The line slot at an even column is
  // overwritten with the current row, so its previous-row value is saved in
  // r_up_left first; it is the top-left pixel of the window closed next column.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < IFM_SIZE; i++) begin
        r_line[i] <= '0;
      end
      r_left    <= '0;
      r_up_left <= '0;
    end else if (i_accept) begin
      r_line[i_col] <= i_pixel;
      if (!i_col[0]) begin
        r_left    <= i_pixel;
        r_up_left <= r_line[i_col];
      end
    end
  end

  // 2x2 combine: signed max tree or floor average, then optional ReLU.
  always_comb begin
    w_a       = r_up_left;
    w_b       = r_line[i_col];
    w_c       = r_left;
    w_d       = i_pixel;
    w_max_top = (w_a > w_b) ? w_a : w_b;
    w_max_bot = (w_c > w_d) ? w_c : w_d;
    w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
    w_sum     = {{2{w_a[DATA_WIDTH-1]}}, w_a} + {{2{w_b[DATA_WIDTH-1]}}, w_b}
              + {{2{w_c[DATA_WIDTH-1]}}, w_c} + {{2{w_d[DATA_WIDTH-1]}}, w_d};
    w_sum_shr = w_sum >>> 2;
    w_avg     = w_sum_shr[DATA_WIDTH-1:0];
    w_pool    = (i_mode_avg == POOL_AVG) ? w_avg : w_max;
`ifdef POOL_RELU_EN
    o_result  = w_pool[DATA_WIDTH-1] ? '0 : w_pool;
`else
    o_result  = w_pool;
`endif
  end

endmodule

// File: rtl/pool_array_dp.sv
// 2x2/stride-2 pooling datapath, NUM_UNITS lanes in parallel, raster-order input
// with valid/ready on both sides. Control FSM, counters and the output register
// live here; per-lane storage and combine live in pool_lane.
// Build option: define POOL_RELU_EN to clamp negative results to zero.
module pool_array_dp
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IFM_SIZE   = 14,
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned NUM_PASSES = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,     // asynchronous, active-low
  input  logic                            i_start,
  input  logic                            i_mode_avg,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] i_in_data,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [NUM_UNITS*DATA_WIDTH-1:0] o_out_data,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int unsigned IFM_SIZE_NEXT = pool_out_size(IFM_SIZE);
  localparam int unsigned COL_W  = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IFM_SIZE - 1);
  localparam logic [COL_W-1:0]  WIN_LIMIT = COL_W'(IFM_SIZE_NEXT);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

  pool_state_t r_state, w_state_d;

  logic [COL_W-1:0]  r_col, w_col_d;
  logic [COL_W-1:0]  r_row, w_row_d;
  logic [PASS_W-1:0] r_pass, w_pass_d;
  logic              r_mode;
  logic              r_out_valid, w_out_valid_d;
  logic [NUM_UNITS*DATA_WIDTH-1:0] r_out_data, w_out_data_d;
  logic [NUM_UNITS*DATA_WIDTH-1:0] w_lane_res;

  logic w_start_ok, w_accept, w_last_beat, w_fire;

  assign w_start_ok  = (r_state == StIdle) && i_start;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_last_beat = w_accept && (r_col == COL_LAST) && (r_row == COL_LAST)
                     && (r_pass == PASS_LAST);
  // A window closes on its bottom-right pixel; the limit drops the stray odd column/row.
  assign w_fire      = w_accept && r_row[0] && r_col[0]
                     && ((r_col >> 1) < WIN_LIMIT) && ((r_row >> 1) < WIN_LIMIT);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_d = StStream;
      StStream: if (w_last_beat) w_state_d = StFlush;
      StFlush:  if (!r_out_valid || i_out_ready) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // FSM-driven outputs.
  always_comb begin
    o_in_ready = (r_state == StStream) && (!r_out_valid || i_out_ready);
    o_busy     = (r_state == StStream) || (r_state == StFlush);
    o_done     = (r_state == StDone);
  end

  // Raster counters: col -> row -> pass, advanced only by accepted beats.
  always_comb begin
    w_col_d  = r_col;
    w_row_d  = r_row;
    w_pass_d = r_pass;
    if (w_start_ok) begin
      w_col_d  = '0;
      w_row_d  = '0;
      w_pass_d = '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        w_col_d = '0;
        if (r_row == COL_LAST) begin
          w_row_d  = '0;
          w_pass_d = (r_pass == PASS_LAST) ? '0 : r_pass + 1'b1;
        end else begin
          w_row_d = r_row + 1'b1;
        end
      end else begin
        w_col_d = r_col + 1'b1;
      end
    end
  end

  // Counter and mode registers; mode is latched only when a frame starts.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pass <= '0;
      r_mode <= POOL_MAX;
    end else begin
      r_col  <= w_col_d;
      r_row  <= w_row_d;
      r_pass <= w_pass_d;
      if (w_start_ok) begin
        r_mode <= i_mode_avg;
      end
    end
  end

  // Output stage: hold until taken; a new result may replace one leaving this cycle.
  always_comb begin
    w_out_valid_d = r_out_valid;
    w_out_data_d  = r_out_data;
    if (i_out_ready) begin
      w_out_valid_d = 1'b0;
    end
    if (w_fire) begin
      w_out_valid_d = 1'b1;
      w_out_data_d  = w_lane_res;
    end
  end

  // Output register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
    pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .IFM_SIZE   (IFM_SIZE)
    ) u_lane (
      .i_clk      (i_clk),
      .i_rst_n    (i_reset),
      .i_accept   (w_accept),
      .i_col      (r_col),
      .i_mode_avg (r_mode),
      .i_pixel    (i_in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_result   (w_lane_res[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
